jtag_tap_sync: RTL and testbench



---
 rtl/jtag_tap_sync_if.sv | 32 +++
 rtl/jtag_tap_sync.sv | 216 +++++++++++++++++++++
 tb/tb_jtag_tap_sync.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_sync_if.sv
// rtl/jtag_tap_sync_if.sv - JTAG pin and configuration-output bundle for jtag_tap_sync
//
// Members:
//   jtag_tck_i, jtag_trst_ni, jtag_tms_i, jtag_tdi_i  JTAG pins driven by the initiator
//   jtag_tdo_o, jtag_tdo_oe_o                         TDO and its output enable
//   conf_reg_o [CONF_WIDTH]                           configuration register toward the SoC
//   conf_update_o                                     one-cycle write strobe for conf_reg_o
//   test_logic_reset_o                                high while the TAP is in Test-Logic-Reset
// Modports: master (initiator side), slave (TAP side).
interface jtag_tap_sync_if #(
    parameter int CONF_WIDTH = 9
);
    logic                  jtag_tck_i;
    logic                  jtag_trst_ni;
    logic                  jtag_tms_i;
    logic                  jtag_tdi_i;
    logic                  jtag_tdo_o;
    logic                  jtag_tdo_oe_o;
    logic [CONF_WIDTH-1:0] conf_reg_o;
    logic                  conf_update_o;
    logic                  test_logic_reset_o;

    modport master (
        output jtag_tck_i, jtag_trst_ni, jtag_tms_i, jtag_tdi_i,
        input  jtag_tdo_o, jtag_tdo_oe_o, conf_reg_o, conf_update_o, test_logic_reset_o
    );

    modport slave (
        input  jtag_tck_i, jtag_trst_ni, jtag_tms_i, jtag_tdi_i,
        output jtag_tdo_o, jtag_tdo_oe_o, conf_reg_o, conf_update_o, test_logic_reset_o
    );
endinterface

// File: rtl/jtag_tap_sync.sv
// rtl/jtag_tap_sync.sv - oversampled IEEE 1149.1 TAP with IDCODE, BYPASS and CONFREG data registers
//
// Ports:
//   clk_i   system clock; every register lives in this domain
//   rst_n   asynchronous active-low reset
//   jtag    jtag_tap_sync_if.slave: TCK/TRST/TMS/TDI in, TDO/TDO-enable, conf_reg_o,
//           conf_update_o and test_logic_reset_o out
// Build option:
//   JTAG_TAP_CONFREG_CAPTURE_EN  when defined, Capture-DR on CONFREG loads the current
//                                conf_reg_o (readback); otherwise it loads zeros.
module jtag_tap_sync #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h249511C3,
    parameter int          CONF_WIDTH   = 9
) (
    input  logic          clk_i,
    input  logic          rst_n,
    jtag_tap_sync_if.slave jtag
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_CONFREG = IR_WIDTH'(6);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_state_t;

    // Every pin passes through the same two-flop depth so TMS/TDI line up with the TCK edge.
    logic tck_s1, tck_s2, tck_d;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic trst_s1, trst_s2;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tck_s1  <= 1'b0;
            tck_s2  <= 1'b0;
            tck_d   <= 1'b0;
            tms_s1  <= 1'b0;
            tms_s2  <= 1'b0;
            tdi_s1  <= 1'b0;
            tdi_s2  <= 1'b0;
            trst_s1 <= 1'b0;
            trst_s2 <= 1'b0;
        end else begin
            tck_s1  <= jtag.jtag_tck_i;
            tck_s2  <= tck_s1;
            tck_d   <= tck_s2;
            tms_s1  <= jtag.jtag_tms_i;
            tms_s2  <= tms_s1;
            tdi_s1  <= jtag.jtag_tdi_i;
            tdi_s2  <= tdi_s1;
            trst_s1 <= jtag.jtag_trst_ni;
            trst_s2 <= trst_s1;
        end
    end

    logic tck_rise, tck_fall;
    assign tck_rise = tck_s2 & ~tck_d;
    assign tck_fall = ~tck_s2 & tck_d;

    tap_state_t state_q, state_d;
    logic       enter_update_dr, enter_update_ir;
    logic       shift_oe_d;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // TRST takes priority over a coincident TCK rise.
    always_comb begin
        state_d = state_q;
        if (!trst_s2) begin
            state_d = TEST_LOGIC_RESET;
        end else if (tck_rise) begin
            unique case (state_q)
                TEST_LOGIC_RESET: state_d = tms_s2 ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_d = tms_s2 ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_DR:        state_d = tms_s2 ? SELECT_IR        : CAPTURE_DR;
                CAPTURE_DR:       state_d = tms_s2 ? EXIT1_DR         : SHIFT_DR;
                SHIFT_DR:         state_d = tms_s2 ? EXIT1_DR         : SHIFT_DR;
                EXIT1_DR:         state_d = tms_s2 ? UPDATE_DR        : PAUSE_DR;
                PAUSE_DR:         state_d = tms_s2 ? EXIT2_DR         : PAUSE_DR;
                EXIT2_DR:         state_d = tms_s2 ? UPDATE_DR        : SHIFT_DR;
                UPDATE_DR:        state_d = tms_s2 ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_IR:        state_d = tms_s2 ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_d = tms_s2 ? EXIT1_IR         : SHIFT_IR;
                SHIFT_IR:         state_d = tms_s2 ? EXIT1_IR         : SHIFT_IR;
                EXIT1_IR:         state_d = tms_s2 ? UPDATE_IR        : PAUSE_IR;
                PAUSE_IR:         state_d = tms_s2 ? EXIT2_IR         : PAUSE_IR;
                EXIT2_IR:         state_d = tms_s2 ? UPDATE_IR        : SHIFT_IR;
                UPDATE_IR:        state_d = tms_s2 ? SELECT_DR        : RUN_TEST_IDLE;
                default:          state_d = TEST_LOGIC_RESET;
            endcase
        end
        enter_update_dr = (state_d == UPDATE_DR) && (state_q != UPDATE_DR);
        enter_update_ir = (state_d == UPDATE_IR) && (state_q != UPDATE_IR);
        shift_oe_d      = (state_d == SHIFT_DR) || (state_d == SHIFT_IR);
    end

    logic [IR_WIDTH-1:0]   ir_q, ir_sr;
    logic [31:0]           idcode_sr;
    logic                  bypass_sr;
    logic [CONF_WIDTH-1:0] conf_sr, conf_reg_q;
    logic                  conf_update_q, tdo_q, tdo_oe_q, tlr_q;

    // Unlisted IR codes fall through to the 1-bit bypass path.
    logic sel_idcode, sel_conf;
    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_conf   = (ir_q == IR_CONFREG);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ir_q          <= IR_IDCODE;
            ir_sr         <= '0;
            idcode_sr     <= '0;
            bypass_sr     <= 1'b0;
            conf_sr       <= '0;
            conf_reg_q    <= '0;
            conf_update_q <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_oe_q      <= 1'b0;
            tlr_q         <= 1'b1;
        end else begin
            conf_update_q <= 1'b0;
            tdo_oe_q      <= shift_oe_d;
            tlr_q         <= (state_d == TEST_LOGIC_RESET);
            if (!trst_s2) begin
                ir_q       <= IR_IDCODE;
                conf_reg_q <= '0;
            end else begin
                if (tck_rise) begin
                    case (state_q)
                        CAPTURE_IR: ir_sr <= IR_WIDTH'(1);
                        SHIFT_IR:   ir_sr <= {tdi_s2, ir_sr[IR_WIDTH-1:1]};
                        CAPTURE_DR: begin
                            if (sel_idcode) begin
                                idcode_sr <= IDCODE_VALUE;
                            end else if (sel_conf) begin
`ifdef JTAG_TAP_CONFREG_CAPTURE_EN
                                conf_sr <= conf_reg_q;
`else
                                conf_sr <= '0;
`endif
                            end else begin
                                bypass_sr <= 1'b0;
                            end
                        end
                        SHIFT_DR: begin
                            if (sel_idcode) begin
                                idcode_sr <= {tdi_s2, idcode_sr[31:1]};
                            end else if (sel_conf) begin
                                conf_sr <= {tdi_s2, conf_sr[CONF_WIDTH-1:1]};
                            end else begin
                                bypass_sr <= tdi_s2;
                            end
                        end
                        default: ;
                    endcase
                end

                // TMS-driven Test-Logic-Reset restores IDCODE but leaves conf_reg_o alone.
                if (state_d == TEST_LOGIC_RESET) begin
                    ir_q <= IR_IDCODE;
                end else if (enter_update_ir) begin
                    ir_q <= ir_sr;
                end

                if (enter_update_dr && sel_conf) begin
                    conf_reg_q    <= conf_sr;
                    conf_update_q <= 1'b1;
                end

                if (tck_fall) begin
                    if (state_q == SHIFT_IR) begin
                        tdo_q <= ir_sr[0];
                    end else if (state_q == SHIFT_DR) begin
                        if (sel_idcode) begin
                            tdo_q <= idcode_sr[0];
                        end else if (sel_conf) begin
                            tdo_q <= conf_sr[0];
                        end else begin
                            tdo_q <= bypass_sr;
                        end
                    end
                end
            end
        end
    end

    assign jtag.jtag_tdo_o         = tdo_q;
    assign jtag.jtag_tdo_oe_o      = tdo_oe_q;
    assign jtag.conf_reg_o         = conf_reg_q;
    assign jtag.conf_update_o      = conf_update_q;
    assign jtag.test_logic_reset_o = tlr_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// tb/tb_jtag_tap_sync.sv - directed self-checking bench for jtag_tap_sync
module tb_jtag_tap_sync;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   pulse_cnt;
    logic [8:0] conf_at_pulse;

    jtag_tap_sync_if #(.CONF_WIDTH(9)) bus ();

    jtag_tap_sync #(
        .IR_WIDTH    (4),
        .IDCODE_VALUE(32'h249511C3),
        .CONF_WIDTH  (9)
    ) dut (
        .clk_i(clk),
        .rst_n(rst_n),
        .jtag (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.conf_update_o === 1'b1) begin
            pulse_cnt++;
            conf_at_pulse = bus.conf_reg_o;
        end
    end

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        bus.jtag_tms_i = tms;
        bus.jtag_tdi_i = tdi;
        #60;
        tdo = bus.jtag_tdo_o;
        bus.jtag_tck_i = 1'b1;
        #60;
        bus.jtag_tck_i = 1'b0;
    endtask

    task automatic goto_tlr_then_idle();
        logic t;
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
        #60;
    endtask

    task automatic to_idle();
        logic t;
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic shift_ir(input logic [3:0] din, output logic [3:0] dout);
        logic t;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        dout = '0;
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, din[i], t);
            dout[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic t;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], t);
            dout[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.jtag_tck_i   = 1'b0;
        bus.jtag_trst_ni = 1'b1;
        bus.jtag_tms_i   = 1'b1;
        bus.jtag_tdi_i   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.jtag_tdo_o !== 1'b0) begin n_bad++; $display("FAIL reset_tdo got %b want 0", bus.jtag_tdo_o); end
        n_cmp++; if (bus.jtag_tdo_oe_o !== 1'b0) begin n_bad++; $display("FAIL reset_tdo_oe got %b want 0", bus.jtag_tdo_oe_o); end
        n_cmp++; if (bus.conf_reg_o !== 9'h000) begin n_bad++; $display("FAIL reset_conf got %h want 000", bus.conf_reg_o); end
        n_cmp++; if (bus.conf_update_o !== 1'b0) begin n_bad++; $display("FAIL reset_update got %b want 0", bus.conf_update_o); end
        n_cmp++; if (bus.test_logic_reset_o !== 1'b1) begin n_bad++; $display("FAIL reset_tlr got %b want 1", bus.test_logic_reset_o); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.test_logic_reset_o !== 1'b1) begin n_bad++; $display("FAIL post_reset_tlr got %b want 1", bus.test_logic_reset_o); end
    endtask

    task automatic test_idcode();
        logic [31:0] d;
        goto_tlr_then_idle();
        n_cmp++; if (bus.test_logic_reset_o !== 1'b1) begin n_bad++; $display("FAIL idcode_tlr got %b want 1", bus.test_logic_reset_o); end
        to_idle();
        #60;
        n_cmp++; if (bus.test_logic_reset_o !== 1'b0) begin n_bad++; $display("FAIL idle_tlr got %b want 0", bus.test_logic_reset_o); end
        shift_dr(32, 32'h0, d);
        n_cmp++; if (d !== 32'h249511C3) begin n_bad++; $display("FAIL idcode_stream got %h want 249511c3", d); end
    endtask

    task automatic test_bypass();
        logic [3:0]  ir_out;
        logic [31:0] d;
        shift_ir(4'b1111, ir_out);
        n_cmp++; if (ir_out !== 4'b0001) begin n_bad++; $display("FAIL ir_capture got %b want 0001", ir_out); end
        shift_dr(9, 32'h0A5, d);
        n_cmp++; if (d[8:0] !== 9'h14A) begin n_bad++; $display("FAIL bypass_stream got %h want 14a", d[8:0]); end
    endtask

    task automatic test_confreg_write();
        logic [3:0]  ir_out;
        logic [31:0] d;
        shift_ir(4'b0110, ir_out);
        pulse_cnt = 0;
        shift_dr(9, 32'h002, d);
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.conf_reg_o !== 9'h002) begin n_bad++; $display("FAIL conf_write got %h want 002", bus.conf_reg_o); end
        n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL conf_pulse_count got %0d want 1", pulse_cnt); end
        n_cmp++; if (conf_at_pulse !== 9'h002) begin n_bad++; $display("FAIL conf_at_pulse got %h want 002", conf_at_pulse); end
    endtask

    task automatic test_confreg_readback();
        logic [31:0] d;
        logic [8:0]  exp_rb;
`ifdef JTAG_TAP_CONFREG_CAPTURE_EN
        exp_rb = 9'h002;
`else
        exp_rb = 9'h000;
`endif
        shift_dr(9, 32'h000, d);
        n_cmp++; if (d[8:0] !== exp_rb) begin n_bad++; $display("FAIL conf_readback got %h want %h", d[8:0], exp_rb); end
        n_cmp++; if (bus.conf_reg_o !== 9'h000) begin n_bad++; $display("FAIL conf_after_readback got %h want 000", bus.conf_reg_o); end
        shift_dr(9, 32'h002, d);
        n_cmp++; if (bus.conf_reg_o !== 9'h002) begin n_bad++; $display("FAIL conf_rewrite got %h want 002", bus.conf_reg_o); end
    endtask

    task automatic test_reset_scopes();
        logic [31:0] d;
        goto_tlr_then_idle();
        n_cmp++; if (bus.test_logic_reset_o !== 1'b1) begin n_bad++; $display("FAIL tms_reset_tlr got %b want 1", bus.test_logic_reset_o); end
        n_cmp++; if (bus.conf_reg_o !== 9'h002) begin n_bad++; $display("FAIL tms_reset_conf got %h want 002", bus.conf_reg_o); end
        to_idle();
        shift_dr(32, 32'h0, d);
        n_cmp++; if (d !== 32'h249511C3) begin n_bad++; $display("FAIL tms_reset_ir got %h want 249511c3", d); end
        @(negedge clk);
        bus.jtag_trst_ni = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (bus.conf_reg_o !== 9'h000) begin n_bad++; $display("FAIL trst_conf got %h want 000", bus.conf_reg_o); end
        n_cmp++; if (bus.test_logic_reset_o !== 1'b1) begin n_bad++; $display("FAIL trst_tlr got %b want 1", bus.test_logic_reset_o); end
        bus.jtag_trst_ni = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_midshift_reset();
        logic [3:0]  ir_out;
        logic [31:0] d;
        logic        t;
        to_idle();
        shift_ir(4'b0110, ir_out);
        shift_dr(9, 32'h1FF, d);
        n_cmp++; if (bus.conf_reg_o !== 9'h1FF) begin n_bad++; $display("FAIL midshift_setup got %h want 1ff", bus.conf_reg_o); end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b1, t);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, t);
        #60;
        n_cmp++; if (bus.jtag_tdo_oe_o !== 1'b1) begin n_bad++; $display("FAIL midshift_oe got %b want 1", bus.jtag_tdo_oe_o); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.jtag_tdo_o !== 1'b0) begin n_bad++; $display("FAIL midshift_tdo got %b want 0", bus.jtag_tdo_o); end
        n_cmp++; if (bus.jtag_tdo_oe_o !== 1'b0) begin n_bad++; $display("FAIL midshift_tdo_oe got %b want 0", bus.jtag_tdo_oe_o); end
        n_cmp++; if (bus.conf_reg_o !== 9'h000) begin n_bad++; $display("FAIL midshift_conf got %h want 000", bus.conf_reg_o); end
        n_cmp++; if (bus.conf_update_o !== 1'b0) begin n_bad++; $display("FAIL midshift_update got %b want 0", bus.conf_update_o); end
        n_cmp++; if (bus.test_logic_reset_o !== 1'b1) begin n_bad++; $display("FAIL midshift_tlr got %b want 1", bus.test_logic_reset_o); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_edge_timing();
        logic t;
        int   lat;
        to_idle();
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        bus.jtag_tms_i = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (bus.jtag_tdo_oe_o !== 1'b0) begin n_bad++; $display("FAIL pre_rise_oe got %b want 0", bus.jtag_tdo_oe_o); end
        bus.jtag_tck_i = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.jtag_tdo_oe_o === 1'b1 && lat == 0) lat = k;
        end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rise_latency got %0d want 3", lat); end
        n_cmp++; if (bus.jtag_tdo_o !== 1'b0) begin n_bad++; $display("FAIL pre_fall_tdo got %b want 0", bus.jtag_tdo_o); end
        @(negedge clk);
        bus.jtag_tck_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.jtag_tdo_o === 1'b1 && lat == 0) lat = k;
        end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL fall_latency got %0d want 3", lat); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        pulse_cnt = 0;
        conf_at_pulse = '0;
        test_reset();
        test_idcode();
        test_bypass();
        test_confreg_write();
        test_confreg_readback();
        test_reset_scopes();
        test_midshift_reset();
        test_edge_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
